// File: rtl/rd_arbiter.sv
// Round-robin arbiter sharing one async-FIFO read port among NREQ read-domain
// consumers. Bursts are capped at BURST pops and a grant stalled on empty is
// released after HOLD cycles.
module rd_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DSIZE = 8,
  parameter int unsigned BURST = 4,
  parameter int unsigned HOLD  = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [NREQ-1:0]  req,
  input  logic             fifo_empty,
  input  logic [DSIZE-1:0] fifo_rdata,
  output logic             fifo_ren,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  rd_ack,
  output logic [DSIZE-1:0] rd_data,
  output logic             busy
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(BURST + 1);
  localparam int unsigned HW = $clog2(HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     owner_q;
  logic [IW-1:0]     last_q;
  logic [CW-1:0]     cnt_q;
  logic [HW-1:0]     hold_q;
  logic [NREQ-1:0]   gnt_q;

  logic [NREQ-1:0]   own_oh;
  logic              req_own;
  logic              in_grant;
  logic              fire;
  logic              burst_done;
  logic              stall_out;
  logic              drop;

  logic [IW-1:0]     cand;
  logic [IW-1:0]     pick_idx;
  logic              pick_vld;

  // Pop qualification and release conditions for the current owner
  assign own_oh     = NREQ'(1) << owner_q;
  assign req_own    = req[owner_q];
  assign in_grant   = (state_q == GRANT);
  assign fire       = in_grant & req_own & ~fifo_empty & ~rrst;
  assign burst_done = fire & (cnt_q == CW'(BURST - 1));
  assign stall_out  = in_grant & req_own & fifo_empty & (hold_q == HW'(HOLD - 1));
  assign drop       = in_grant & (burst_done | ~req_own | stall_out);

  assign fifo_ren = fire;
  assign rd_ack   = fire ? own_oh : '0;
  assign rd_data  = fifo_rdata;
  assign gnt      = gnt_q;
  assign busy     = |gnt_q;

  // Round-robin search starting just after the last served requester
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(last_q) + k) % NREQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Grant state machine with burst and empty-stall counters
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld && !fifo_empty) begin
            state_q <= GRANT;
            owner_q <= pick_idx;
            gnt_q   <= NREQ'(1) << pick_idx;
            cnt_q   <= '0;
            hold_q  <= '0;
          end
        end
        GRANT: begin
          if (drop) begin
            state_q <= IDLE;
            last_q  <= owner_q;
            gnt_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
          end else if (fire) begin
            cnt_q  <= cnt_q + CW'(1);
            hold_q <= '0;
          end else if (req_own && fifo_empty) begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_arbiter.sv
// Scoreboard bench for rd_arbiter: the bench plays the FIFO, pushes each word
// with its intended consumer, and matches every rd_ack against that queue.
module tb_rd_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DSIZE = 8;
  localparam int unsigned LOGN  = 64;

  logic             rclk = 1'b0;
  logic             rrst;
  logic [NREQ-1:0]  req;
  logic             fifo_empty;
  logic [DSIZE-1:0] fifo_rdata;
  logic             fifo_ren;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  rd_ack;
  logic [DSIZE-1:0] rd_data;
  logic             busy;

  rd_arbiter #(.NREQ(4), .DSIZE(8), .BURST(4), .HOLD(8)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .req        (req),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_ren   (fifo_ren),
    .gnt        (gnt),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .busy       (busy)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    int         who;
    logic [7:0] data;
  } exp_t;

  logic [7:0] fifo_m[$];
  exp_t       exp_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         cyc   = 0;
  int         wcnt  = 0;

  logic [NREQ-1:0] gl[LOGN];
  logic [NREQ-1:0] al[LOGN];
  logic            rl[LOGN];
  logic            bl[LOGN];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fifo_m.size() == 0);
    fifo_rdata = fifo_empty ? 8'h00 : fifo_m[0];
  endtask

  task automatic push_word(input int who);
    exp_t e;
    logic [7:0] d;
    d = 8'(wcnt * 37 + 11);
    wcnt++;
    fifo_m.push_back(d);
    e.who  = who;
    e.data = d;
    exp_q.push_back(e);
    drive_fifo();
  endtask

  // One read-clock cycle: sample at negedge, score acks, pop FIFO model at the edge
  task automatic tick(input int n = 1);
    exp_t e;
    logic pop;
    for (int i = 0; i < n; i++) begin
      @(negedge rclk);
      if (cyc < LOGN) begin
        gl[cyc] = gnt;
        al[cyc] = rd_ack;
        rl[cyc] = fifo_ren;
        bl[cyc] = busy;
      end
      chk_eq("ren_while_empty", 32'(fifo_ren & fifo_empty), 32'd0);
      if (!fifo_ren) chk_eq("ack_without_ren", 32'(rd_ack), 32'd0);
      else           chk_eq("ren_without_ack", 32'(rd_ack != '0), 32'd1);
      if (rd_ack != '0) begin
        if (exp_q.size() == 0) begin
          chk_eq("unexpected_ack", 32'(rd_ack), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk_eq("ack_who", 32'(rd_ack), 32'd1 << e.who);
          chk_eq("ack_data", 32'(rd_data), 32'(e.data));
        end
      end
      pop = fifo_ren;
      @(posedge rclk);
      #1;
      if (pop && fifo_m.size() > 0) void'(fifo_m.pop_front());
      drive_fifo();
      cyc++;
    end
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    req  = '0;
    fifo_m.delete();
    exp_q.delete();
    drive_fifo();
    tick(1);
    rrst = 1'b0;
    cyc  = 0;
  endtask

  task automatic drain(input int budget, output int used);
    used = 0;
    while (exp_q.size() != 0 && used < budget) begin
      tick(1);
      used++;
    end
    chk_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int used;
    int cnt;
    logic [NREQ-1:0] gor, aor;
    logic ror;
    exp_t e;

    // Reset state, with requests pending and data available
    rrst = 1'b1;
    req  = 4'hF;
    fifo_m.push_back(8'hA5);
    drive_fifo();
    repeat (2) @(posedge rclk);
    #1;
    tick(1);
    chk_eq("rst_gnt",  32'(gl[0]), 32'd0);
    chk_eq("rst_busy", 32'(bl[0]), 32'd0);
    chk_eq("rst_ren",  32'(rl[0]), 32'd0);
    chk_eq("rst_ack",  32'(al[0]), 32'd0);

    // 1: single requester, 10 words -> runs of 4,4,2 with one bubble between
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 10; i++) push_word(0);
    tick(14);
    for (int i = 0; i < 14; i++) begin
      chk_eq("t1_busy", 32'(bl[i]), (i == 0 || i == 5 || i == 10) ? 32'd0 : 32'd1);
      chk_eq("t1_ack",  32'(al[i]),
             (i == 0 || i == 5 || i == 10 || i == 13) ? 32'd0 : 32'd1);
    end
    req = '0;
    tick(2);
    chk_eq("t1_gnt_off", 32'(gl[15]), 32'd0);
    chk_eq("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // 2: all requesting, never empty -> 0,1,2,3,0,... bursts of 4, one bubble each
    do_reset();
    req = 4'hF;
    for (int i = 0; i < 32; i++) push_word((i / 4) % 4);
    drain(80, used);
    chk_eq("t2_cycles", 32'(used), 32'd40);
    cnt = 0;
    for (int i = 0; i < 40; i++) if (gl[i] == '0) cnt++;
    chk_eq("t2_bubbles", 32'(cnt), 32'd8);
    chk_eq("t2_g1",  32'(gl[1]),  32'h1);
    chk_eq("t2_g6",  32'(gl[6]),  32'h2);
    chk_eq("t2_g11", 32'(gl[11]), 32'h4);
    chk_eq("t2_g16", 32'(gl[16]), 32'h8);
    chk_eq("t2_g21", 32'(gl[21]), 32'h1);
    req = '0;
    tick(2);

    // 3a: stalls inside one grant; each refill pop clears the stall count
    do_reset();
    req = 4'b0010;
    push_word(1);
    push_word(1);
    tick(8);
    push_word(1);
    tick(8);
    push_word(1);
    tick(2);
    chk_eq("t3_stall_ack", 32'(al[3]),  32'd0);
    chk_eq("t3_refill1",   32'(al[8]),  32'h2);
    chk_eq("t3_held",      32'(gl[15]), 32'h2);
    chk_eq("t3_last_pop",  32'(al[16]), 32'h2);
    chk_eq("t3_burst_end", 32'(gl[17]), 32'd0);
    // 3b: refill never comes -> release after 8 empty cycles
    push_word(1);
    tick(11);
    chk_eq("t3b_idle",     32'(gl[18]), 32'd0);
    chk_eq("t3b_pop",      32'(al[19]), 32'h2);
    chk_eq("t3b_hold7",    32'(gl[27]), 32'h2);
    chk_eq("t3b_released", 32'(gl[28]), 32'd0);
    req = '0;
    tick(1);
    chk_eq("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4: owner withdraws after one pop -> release, next requester one cycle later
    do_reset();
    req = 4'b0011;
    push_word(0);
    for (int i = 0; i < 3; i++) push_word(1);
    tick(2);
    req = 4'b0010;
    tick(5);
    chk_eq("t4_first_pop", 32'(al[1]), 32'h1);
    chk_eq("t4_no_ren",    32'(rl[2]), 32'd0);
    chk_eq("t4_gnt_rel",   32'(gl[2]), 32'h1);
    chk_eq("t4_bubble",    32'(gl[3]), 32'd0);
    chk_eq("t4_gnt1",      32'(gl[4]), 32'h2);
    chk_eq("t4_ack1",      32'(al[4]), 32'h2);
    req = '0;
    tick(3);
    chk_eq("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // 5: reset mid-burst of requester 2 -> no pop in reset cycle, requester 0 wins after
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 10; i++) push_word(2);
    tick(3);
    rrst = 1'b1;
    req  = 4'hF;
    exp_q.delete();
    for (int k = 0; k < fifo_m.size(); k++) begin
      e.who  = k / 4;
      e.data = fifo_m[k];
      exp_q.push_back(e);
    end
    tick(1);
    rrst = 1'b0;
    drain(40, used);
    chk_eq("t5_rst_ren",  32'(rl[3]), 32'd0);
    chk_eq("t5_rst_ack",  32'(al[3]), 32'd0);
    chk_eq("t5_post_gnt", 32'(gl[4]), 32'd0);
    chk_eq("t5_post_busy",32'(bl[4]), 32'd0);
    chk_eq("t5_post_ren", 32'(rl[4]), 32'd0);
    chk_eq("t5_first",    32'(gl[5]), 32'h1);
    chk_eq("t5_cycles",   32'(used),  32'd10);
    req = '0;
    tick(2);

    // 6: empty FIFO with all requesting -> no grant until data arrives
    do_reset();
    req = 4'hF;
    tick(20);
    gor = '0;
    aor = '0;
    ror = 1'b0;
    for (int i = 0; i < 20; i++) begin
      gor |= gl[i];
      aor |= al[i];
      ror |= rl[i];
    end
    chk_eq("t6_no_gnt", 32'(gor), 32'd0);
    chk_eq("t6_no_ack", 32'(aor), 32'd0);
    chk_eq("t6_no_ren", 32'(ror), 32'd0);
    for (int i = 0; i < 4; i++) push_word(0);
    tick(5);
    chk_eq("t6_idle",  32'(gl[20]), 32'd0);
    chk_eq("t6_gnt0",  32'(gl[21]), 32'h1);
    chk_eq("t6_ack0",  32'(al[21]), 32'h1);
    req = '0;
    tick(2);
    chk_eq("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
